ulpi_init_seq: RTL



---
 rtl/ulpi_pkg.sv | 31 +++
 rtl/ulpi_init_seq_if.sv | 12 +
 rtl/ulpi_init_rom.sv | 14 +
 rtl/ulpi_init_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// ulpi_pkg: ULPI register map, init-table record type and sequencer encodings
package ulpi_pkg;
  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] OTG_CTRL = 6'h0A;
  localparam logic [5:0] VENDOR_ID_LO = 6'h00;
  localparam logic [7:0] FC_XCVR_FS = 8'h01;
  localparam logic [7:0] FC_TERM_SEL = 8'h04;
  localparam logic [7:0] FC_OPMODE_NORM = 8'h00;
  localparam logic [7:0] FC_SUSPENDM = 8'h40;
  localparam logic [7:0] FUNC_CTRL_INIT = FC_SUSPENDM | FC_TERM_SEL | FC_XCVR_FS | FC_OPMODE_NORM;
  localparam logic [7:0] OTG_CTRL_INIT = 8'h00;
  typedef enum logic [1:0] {ERR_NONE, ERR_FAIL, ERR_TIMEOUT, ERR_MISMATCH} err_t;
  typedef enum logic [2:0] {S_WAIT_READY, S_ISSUE, S_WAIT_RESP, S_GAP, S_DONE, S_ERROR} state_t;
  typedef struct packed {
    logic rw;
    logic [5:0] addr;
    logic [7:0] data;
    logic check;
  } step_t;
  localparam int N_STEPS = 4;
  localparam int STEP_W = 3;
  localparam step_t INIT_TABLE [N_STEPS] = '{
    '{1'b1, FUNC_CTRL, FUNC_CTRL_INIT, 1'b0},
    '{1'b1, OTG_CTRL, OTG_CTRL_INIT, 1'b0},
    '{1'b0, FUNC_CTRL, FUNC_CTRL_INIT, 1'b1},
    '{1'b0, OTG_CTRL, OTG_CTRL_INIT, 1'b1}
  };
  function automatic logic read_mismatch(step_t e, logic [7:0] rd);
    return !e.rw && e.check && rd != e.data;
  endfunction
endpackage

// File: rtl/ulpi_init_seq_if.sv
// ulpi_init_seq_if: strobe-based ULPI register-access port
interface ulpi_init_seq_if;
  logic REG_EN;
  logic REG_RW;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I;
  logic REG_DONE;
  logic REG_FAIL;
  logic [7:0] REG_DATA_O;
  modport master(output REG_EN, REG_RW, REG_ADDR, REG_DATA_I, input REG_DONE, REG_FAIL, REG_DATA_O);
  modport slave(input REG_EN, REG_RW, REG_ADDR, REG_DATA_I, output REG_DONE, REG_FAIL, REG_DATA_O);
endinterface

// File: rtl/ulpi_init_rom.sv
// ulpi_init_rom: step index to init-table entry lookup
module ulpi_init_rom
  import ulpi_pkg::*;
(
  input logic [STEP_W-1:0] step,
  output step_t entry
);
  // Indices past the table read as an all-zero entry
  always_comb begin
    entry = '0;
    for (int i = 0; i < N_STEPS; i++)
      if (step == STEP_W'(i)) entry = INIT_TABLE[i];
  end
endmodule

// File: rtl/ulpi_init_seq.sv
// ulpi_init_seq: replays the ULPI init table through the register port with retry/timeout
module ulpi_init_seq
  import ulpi_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT = 1023
) (
  input logic CLK_60M,
  input logic NRST_A_USB,
  input logic START,
  input logic READY,
  ulpi_init_seq_if.master port,
  output logic INIT_BUSY,
  output logic INIT_DONE,
  output logic INIT_ERR,
  output logic [2:0] ERR_STEP,
  output logic [1:0] ERR_CODE
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RTW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_t state, state_n;
  logic [STEP_W-1:0] step, step_n, err_step, err_step_n;
  logic [RTW-1:0] retry, retry_n;
  logic [CW-1:0] cnt, cnt_n;
  err_t err_code, err_code_n, retry_code;
  step_t entry;
  logic timeout;
  ulpi_init_rom rom (.step(step), .entry(entry));
  assign port.REG_EN = state == S_ISSUE;
  assign ERR_STEP = err_step;
  assign ERR_CODE = err_code;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign retry_code = port.REG_FAIL ? ERR_FAIL : ERR_TIMEOUT;
  // Next state: response handling, retry budget, and abandon on READY loss
  always_comb begin
    state_n = state;
    step_n = step;
    retry_n = retry;
    cnt_n = cnt;
    err_step_n = err_step;
    err_code_n = err_code;
    case (state)
      S_WAIT_READY: state_n = READY ? S_ISSUE : S_WAIT_READY;
      S_ISSUE: begin
        cnt_n = '0;
        state_n = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        cnt_n = cnt + 1'b1;
        if (port.REG_FAIL || (!port.REG_DONE && timeout)) begin
          if (retry < RTW'(MAX_RETRY)) begin
            retry_n = retry + 1'b1;
            state_n = S_GAP;
          end else begin
            state_n = S_ERROR;
            err_step_n = step;
            err_code_n = retry_code;
          end
        end else if (port.REG_DONE) begin
          if (read_mismatch(entry, port.REG_DATA_O)) begin
            state_n = S_ERROR;
            err_step_n = step;
            err_code_n = ERR_MISMATCH;
          end else begin
            step_n = step + 1'b1;
            retry_n = '0;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: state_n = step == STEP_W'(N_STEPS) ? S_DONE : S_ISSUE;
      S_DONE, S_ERROR: if (START) begin
        state_n = S_WAIT_READY;
        step_n = '0;
        retry_n = '0;
        err_step_n = '0;
        err_code_n = ERR_NONE;
      end
      default: state_n = S_WAIT_READY;
    endcase
    if (!READY && state inside {S_ISSUE, S_WAIT_RESP, S_GAP}) begin
      state_n = S_WAIT_READY;
      step_n = '0;
      retry_n = '0;
      err_step_n = err_step;
      err_code_n = err_code;
    end
  end
  // State/datapath registers; access fields load on entry to ISSUE and hold through the response
  always_ff @(posedge CLK_60M or negedge NRST_A_USB)
    if (!NRST_A_USB) begin
      state <= S_WAIT_READY;
      step <= '0;
      retry <= '0;
      cnt <= '0;
      err_step <= '0;
      err_code <= ERR_NONE;
      port.REG_RW <= 1'b0;
      port.REG_ADDR <= '0;
      port.REG_DATA_I <= '0;
      INIT_BUSY <= 1'b0;
      INIT_DONE <= 1'b0;
      INIT_ERR <= 1'b0;
    end else begin
      state <= state_n;
      step <= step_n;
      retry <= retry_n;
      cnt <= cnt_n;
      err_step <= err_step_n;
      err_code <= err_code_n;
      if (state_n == S_ISSUE) begin
        port.REG_RW <= entry.rw;
        port.REG_ADDR <= entry.addr;
        port.REG_DATA_I <= entry.data;
      end
      INIT_BUSY <= !(state_n inside {S_DONE, S_ERROR});
      INIT_DONE <= state_n == S_DONE;
      INIT_ERR <= state_n == S_ERROR;
    end
endmodule
